// File: rtl/bus_requester.sv
// Master-side bus agent: buffers write beats in a small FIFO, requests the shared
// bus once a full burst (or a full FIFO) is waiting, and issues beats while granted.
module bus_requester #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_last,
    output logic                  req,
    input  logic                  grant,
    output logic                  bus_valid,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_last,
    output logic                  burst_done,
    output logic                  timeout_err,
    output logic [15:0]           beat_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(GRANT_TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

    typedef struct packed {
        logic                  last;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    pending;
    logic [WAIT_W-1:0]   wait_cnt;
    state_t              state;
    entry_t              head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                push_last;
    logic                pop_last;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];
    assign pop       = ((state == REQ) || (state == XFER)) && grant && !empty;
    assign push_last = push && cmd_last;
    assign pop_last  = pop && head.last;

    // NOTE: the storage array is deliberately not reset; valid data is tracked by
    // the pointers and count, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{last: cmd_last, addr: cmd_addr, data: cmd_data};
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({push_last, pop_last})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req         <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            bus_valid   <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_last    <= 1'b0;
            burst_done  <= 1'b0;
            beat_count  <= '0;
        end else begin
            timeout_err <= 1'b0;
            bus_valid   <= pop;
            bus_last    <= pop_last;
            burst_done  <= pop_last;
            if (pop) begin
                bus_addr   <= head.addr;
                bus_wdata  <= head.data;
                beat_count <= beat_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if ((pending != '0) || full) begin
                        state    <= REQ;
                        req      <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (pop) begin
                        wait_cnt <= '0;
                        if (head.last) begin
                            state <= RELEASE;
                            req   <= 1'b0;
                        end else begin
                            state <= XFER;
                        end
                    end else if (!grant) begin
                        // Give up the request slot; buffered beats stay for the retry.
                        if (wait_cnt == WAIT_W'(GRANT_TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= RELEASE;
                            req         <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (pop) wait_cnt <= '0;
                    if (pop_last) begin
                        state <= RELEASE;
                        req   <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester: directed scenarios plus a random run,
// checked against a beat-queue scoreboard and FIFO-occupancy model.
module tb_bus_requester;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_last;
    logic        req;
    logic        grant;
    logic        bus_valid;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_last;
    logic        burst_done;
    logic        timeout_err;
    logic [15:0] beat_count;

    bus_requester dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_last   (cmd_last),
        .req        (req),
        .grant      (grant),
        .bus_valid  (bus_valid),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_last   (bus_last),
        .burst_done (burst_done),
        .timeout_err(timeout_err),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    int          to_seen = 0;
    int          accepted_total = 0;
    logic [15:0] hold_addr = '0;
    logic [31:0] hold_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at a negedge, let the posedge happen, then check the
    // registered outputs at the following negedge against the scoreboard.
    task automatic tick(input logic v, input logic [15:0] a, input logic [31:0] d,
                        input logic l, input logic g);
        beat_t b;
        check("cmd_ready", cmd_ready, sb.size() != DEPTH);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_last  = l;
        grant     = g;
        if (v && sb.size() != DEPTH) begin
            b.addr = a;
            b.data = d;
            b.last = l;
            sb.push_back(b);
            accepted_total++;
        end
        @(negedge clk);
        if (timeout_err === 1'b1) to_seen++;
        if (bus_valid === 1'b1) begin
            check("beat_without_grant", g, 1'b1);
            if (sb.size() == 0) begin
                check("unexpected_beat", bus_valid, 1'b0);
            end else begin
                b = sb.pop_front();
                check("bus_addr", bus_addr, b.addr);
                check("bus_wdata", bus_wdata, b.data);
                check("bus_last", bus_last, b.last);
                check("burst_done", burst_done, b.last);
                hold_addr = b.addr;
                hold_data = b.data;
                if (b.last) done_seen++;
            end
        end else begin
            check("bus_valid_idle", bus_valid, 1'b0);
            check("burst_done_idle", burst_done, 1'b0);
            check("bus_addr_hold", bus_addr, hold_addr);
            check("bus_wdata_hold", bus_wdata, hold_data);
        end
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, g);
    endtask

    task automatic do_reset(input logic g);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        grant     = g;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        hold_addr = '0;
        hold_data = '0;
        check("rst_req", req, 1'b0);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_beat_count", beat_count, 16'd0);
        check("rst_burst_done", burst_done, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_bus_addr", bus_addr, 16'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int t0;
        int acc0;
        int acc_before;
        logic g;

        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_last  = 1'b0;
        grant     = 1'b0;
        reset     = 1'b1;

        // Basic 3-beat burst with grant held high.
        do_reset(1'b0);
        d0 = done_seen;
        t0 = to_seen;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'h0010 + 16'(i), 32'h0000_00A0 + 32'(i), i == 2, 1'b1);
            check("s1_req_while_filling", req, 1'b0);
        end
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s1_req_rise", req, 1'b1);
        check("s1_no_beat_yet", bus_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1);
            check("s1_beat_valid", bus_valid, 1'b1);
            check("s1_req_during", req, i != 2);
        end
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s1_req_low_gap", req, 1'b0);
        check("s1_beat_count", beat_count, 16'd3);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s1_req_stays_low", req, 1'b0);
        check("s1_done_count", done_seen - d0, 1);
        check("s1_no_timeout", to_seen - t0, 0);

        // 4-beat burst with grant toggling every cycle.
        d0 = done_seen;
        for (int i = 0; i < 4; i++)
            tick(1'b1, 16'h0020 + 16'(i), $urandom, i == 3, 1'b0);
        check("s2_full_ready", cmd_ready, 1'b0);
        check("s2_req_before", req, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("s2_req_rise", req, 1'b1);
        for (int i = 0; i < 7; i++) begin
            g = (i % 2 == 0);
            tick(1'b0, '0, '0, 1'b0, g);
            check("s2_beat_follows_grant", bus_valid, g);
            check("s2_req_held", req, i != 6);
        end
        check("s2_done_once", done_seen - d0, 1);
        check("s2_beat_count", beat_count, 16'd7);
        check("s2_no_timeout", to_seen - t0, 0);
        idle(2, 1'b0);

        // Grant withheld: timeout, release, retry, then deliver intact.
        t0 = to_seen;
        tick(1'b1, 16'h0030, 32'hC0C0_0030, 1'b0, 1'b0);
        tick(1'b1, 16'h0031, 32'hC0C0_0031, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("s3_req_rise", req, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0);
            check("s3_timeout_pulse", timeout_err, i == 16);
            check("s3_req_wait", req, i != 16);
        end
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("s3_req_gap", req, 1'b0);
        check("s3_timeout_one_cycle", timeout_err, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("s3_req_retry", req, 1'b1);
        check("s3_fifo_intact", sb.size(), 2);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s3_beat0", bus_valid, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s3_beat1_last", bus_last, 1'b1);
        check("s3_req_release", req, 1'b0);
        check("s3_beat_count", beat_count, 16'd9);
        check("s3_timeouts", to_seen - t0, 1);
        idle(2, 1'b0);

        // Full FIFO without a last beat forces a request; burst spans a refill.
        t0 = to_seen;
        for (int i = 0; i < 4; i++)
            tick(1'b1, 16'h0040 + 16'(i), 32'hD000_0040 + 32'(i), 1'b0, 1'b0);
        check("s4_full_ready", cmd_ready, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("s4_req_on_full", req, 1'b1);
        // Offer a beat during the pop at full: it must not be accepted.
        tick(1'b1, 16'h004F, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("s4_beat", bus_valid, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1);
            check("s4_beat", bus_valid, 1'b1);
            check("s4_req", req, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1);
            check("s4_stall_no_beat", bus_valid, 1'b0);
            check("s4_stall_req", req, 1'b1);
        end
        tick(1'b1, 16'h0044, 32'hD000_0044, 1'b1, 1'b1);
        check("s4_push_no_beat", bus_valid, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s4_last_beat", bus_last, 1'b1);
        check("s4_req_release", req, 1'b0);
        check("s4_beat_count", beat_count, 16'd14);
        check("s4_no_timeout", to_seen - t0, 0);
        idle(2, 1'b0);

        // Reset in the middle of a burst, then a fresh burst.
        d0 = done_seen;
        for (int i = 0; i < 4; i++)
            tick(1'b1, 16'h0060 + 16'(i), 32'hE000_0060 + 32'(i), i == 3, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("s6_beat_count_pre", beat_count, 16'd16);
        do_reset(1'b1);
        check("s6_no_done", done_seen - d0, 0);
        for (int i = 0; i < 3; i++)
            tick(1'b1, 16'h0070 + 16'(i), 32'hF000_0070 + 32'(i), i == 2, 1'b1);
        idle(5, 1'b1);
        check("s6_new_burst_count", beat_count, 16'd3);
        check("s6_new_burst_done", done_seen - d0, 1);

        // Random traffic against the scoreboard, then drain.
        acc0 = accepted_total;
        for (int i = 0; i < 80; i++)
            tick($urandom_range(0, 3) != 0, 16'($urandom), $urandom,
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        acc_before = accepted_total;
        for (int i = 0; i < 30 && accepted_total == acc_before; i++)
            tick(1'b1, 16'h7FFF, 32'h5A5A_5A5A, 1'b1, 1'b1);
        check("rnd_final_push", accepted_total - acc_before, 1);
        for (int i = 0; i < 60 && sb.size() != 0; i++)
            tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("rnd_drained", sb.size(), 0);
        check("rnd_beat_count", beat_count, 16'(3 + accepted_total - acc0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
